// File: rtl/gpr_wb_arbiter_pkg.sv
// Shared CPU definitions for the GPR writeback path: default widths and
// the requester identities used by the writeback round-robin pointer.
package gpr_wb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    // Writeback requesters; the value doubles as the round-robin pointer
    // encoding (the pointer names the requester favoured on contention).
    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_e;

    // The requester that should be favoured after `id` was granted.
    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_ALU) ? REQ_LOAD : REQ_ALU;
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Register scoreboard: one pending bit per GPR, set at issue and cleared
// by the GPR write, plus the combinational RAW/WAW hazard check.
module gpr_scoreboard
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] src1_rd,
    input  logic [REG_AW-1:0] src2_rd,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_rd,
    output logic              stall
);

    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0] pending;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] pending_next;

    // Hazard check: any pending source (RAW) or pending destination (WAW).
    // Bit 0 is never set, so r0 can never stall; reset masks the output.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            stall = pending[src1_rd] | pending[src2_rd] |
                    (issue_valid & pending[issue_rd]);
        end
    end

    // Next pending vector: clear on write, then set on issue so that a
    // same-cycle set and clear of one register leaves it pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && !stall && (issue_rd != '0)) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (wr_en) begin
            clr_mask[wr_rd] = 1'b1;
        end
        pending_next    = (pending & ~clr_mask) | set_mask;
        pending_next[0] = 1'b0;
    end

    // Pending state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR writeback arbiter: round-robin between the ALU and load unit onto the
// single GPR write port through a one-cycle write stage, with the register
// scoreboard stalling decode on RAW/WAW hazards.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [REG_AW-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [REG_AW-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] src1_rd,
    input  logic [REG_AW-1:0] src2_rd,
    output logic              stall,
    output logic              RegWrite,
    output logic [REG_AW-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData
);

    req_id_e           rr_ptr;
    logic              a_acc;
    logic              b_acc;
    logic              accept;
    logic [REG_AW-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    // Readies look only at the other side's valid and the pointer, never at
    // the other ready. The write stage never back-pressures, so a lone
    // requester is always taken; on contention only the favoured one is.
    always_comb begin
        a_ready = !rst && (!b_valid || (rr_ptr == REQ_ALU));
        b_ready = !rst && (!a_valid || (rr_ptr == REQ_LOAD));
    end

    // Grant decode and mux of the accepted request.
    always_comb begin
        a_acc    = a_valid && a_ready;
        b_acc    = b_valid && b_ready;
        accept   = a_acc || b_acc;
        sel_rd   = b_acc ? b_rd   : a_rd;
        sel_data = b_acc ? b_data : a_data;
    end

    // Round-robin pointer: after any acceptance favour the other requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= REQ_LOAD;
        end else if (a_acc) begin
            rr_ptr <= other_req(REQ_ALU);
        end else if (b_acc) begin
            rr_ptr <= other_req(REQ_LOAD);
        end
    end

    // Write stage: register the accepted request; writes to r0 are consumed
    // without raising RegWrite. Reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= accept && (sel_rd != '0);
            if (accept) begin
                WriteRegister <= sel_rd;
                WriteData     <= sel_data;
            end
        end
    end

    gpr_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .src1_rd     (src1_rd),
        .src2_rd     (src2_rd),
        .wr_en       (RegWrite),
        .wr_rd       (WriteRegister),
        .stall       (stall)
    );

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: arbitration, write-stage latency,
// scoreboard hazards, r0 handling and mid-operation reset.
module tb_gpr_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid;
    logic [REG_AW-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [REG_AW-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              issue_valid;
    logic [REG_AW-1:0] issue_rd;
    logic [REG_AW-1:0] src1_rd;
    logic [REG_AW-1:0] src2_rd;
    logic              stall;
    logic              RegWrite;
    logic [REG_AW-1:0] WriteRegister;
    logic [DATA_W-1:0] WriteData;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    gpr_wb_arbiter #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .a_valid       (a_valid),
        .a_rd          (a_rd),
        .a_data        (a_data),
        .a_ready       (a_ready),
        .b_valid       (b_valid),
        .b_rd          (b_rd),
        .b_data        (b_data),
        .b_ready       (b_ready),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .src1_rd       (src1_rd),
        .src2_rd       (src2_rd),
        .stall         (stall),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData)
    );

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1ns after it, well away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_rd = '0; a_data = '0;
        b_valid = 0; b_rd = '0; b_data = '0;
        issue_valid = 0; issue_rd = '0; src1_rd = '0; src2_rd = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        a_valid = 1; a_rd = 5'd1; b_valid = 1; b_rd = 5'd2;
        issue_valid = 1; issue_rd = 5'd3;
        tick();
        tick();
        tests++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            failed++;
            $display("FAIL reset_ready: a_ready=%b b_ready=%b expected 0 0", a_ready, b_ready);
        end
        tests++;
        if (stall !== 1'b0) begin
            failed++;
            $display("FAIL reset_stall: got %b expected 0", stall);
        end
        tests++;
        if (RegWrite !== 1'b0 || WriteRegister !== '0 || WriteData !== '0) begin
            failed++;
            $display("FAIL reset_wport: RegWrite=%b WR=%0d WD=%h expected 0 0 0",
                     RegWrite, WriteRegister, WriteData);
        end
        idle_inputs();
        rst = 0;
        tick();
        // Issue of r3 was presented during reset; it must not have left r3 pending.
        src1_rd = 5'd3;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            failed++;
            $display("FAIL reset_no_pending: stall=%b expected 0", stall);
        end
        idle_inputs();
    endtask

    task automatic test_single();
        a_valid = 1; a_rd = 5'd5; a_data = 32'h1234;
        #1;
        tests++;
        if (a_ready !== 1'b1) begin
            failed++;
            $display("FAIL single_ready: a_ready=%b expected 1", a_ready);
        end
        tick();
        a_valid = 0;
        tests++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 32'h1234) begin
            failed++;
            $display("FAIL single_write: RegWrite=%b WR=%0d WD=%h expected 1 5 1234",
                     RegWrite, WriteRegister, WriteData);
        end
        tick();
        tests++;
        if (RegWrite !== 1'b0) begin
            failed++;
            $display("FAIL single_idle: RegWrite=%b expected 0", RegWrite);
        end
    endtask

    task automatic test_contention();
        logic       exp_b [4];
        logic [4:0] exp_rd [4];
        exp_b  = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_rd = '{5'd4, 5'd3, 5'd4, 5'd3};
        idle_inputs();
        do_reset();
        a_valid = 1; a_rd = 5'd3; a_data = 32'hAAAA_0003;
        b_valid = 1; b_rd = 5'd4; b_data = 32'hBBBB_0004;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (b_ready !== exp_b[i] || a_ready !== !exp_b[i]) begin
                failed++;
                $display("FAIL contention_grant%0d: a_ready=%b b_ready=%b expected %b %b",
                         i, a_ready, b_ready, !exp_b[i], exp_b[i]);
            end
            tick();
            tests++;
            if (RegWrite !== 1'b1 || WriteRegister !== exp_rd[i] ||
                WriteData !== (exp_b[i] ? 32'hBBBB_0004 : 32'hAAAA_0003)) begin
                failed++;
                $display("FAIL contention_write%0d: RegWrite=%b WR=%0d WD=%h expected 1 %0d",
                         i, RegWrite, WriteRegister, WriteData, exp_rd[i]);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_hazard();
        issue_valid = 1; issue_rd = 5'd7;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            failed++;
            $display("FAIL hazard_issue: stall=%b expected 0", stall);
        end
        tick();
        issue_valid = 0; src1_rd = 5'd7;
        #1;
        tests++;
        if (stall !== 1'b1) begin
            failed++;
            $display("FAIL hazard_raw: stall=%b expected 1", stall);
        end
        // WAW: a second issue to r7 must also stall.
        issue_valid = 1; src1_rd = 5'd0;
        #1;
        tests++;
        if (stall !== 1'b1) begin
            failed++;
            $display("FAIL hazard_waw: stall=%b expected 1", stall);
        end
        issue_valid = 0; src1_rd = 5'd7;
        tick();
        a_valid = 1; a_rd = 5'd7; a_data = 32'h0000_0777;
        tick();
        a_valid = 0;
        tests++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || stall !== 1'b1) begin
            failed++;
            $display("FAIL hazard_wb_cycle: RegWrite=%b WR=%0d stall=%b expected 1 7 1",
                     RegWrite, WriteRegister, stall);
        end
        tick();
        tests++;
        if (stall !== 1'b0) begin
            failed++;
            $display("FAIL hazard_cleared: stall=%b expected 0", stall);
        end
        idle_inputs();
    endtask

    task automatic test_same_cycle();
        // r9 is not pending: the writeback is still performed.
        a_valid = 1; a_rd = 5'd9; a_data = 32'h0000_0999;
        tick();
        a_valid = 0;
        issue_valid = 1; issue_rd = 5'd9;
        #1;
        tests++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd9 || WriteData !== 32'h0000_0999 ||
            stall !== 1'b0) begin
            failed++;
            $display("FAIL same_cycle_wb: RegWrite=%b WR=%0d WD=%h stall=%b expected 1 9 999 0",
                     RegWrite, WriteRegister, WriteData, stall);
        end
        tick();
        issue_valid = 0; src2_rd = 5'd9;
        #1;
        tests++;
        if (stall !== 1'b1) begin
            failed++;
            $display("FAIL same_cycle_set_wins: stall=%b expected 1", stall);
        end
        tick();
        tests++;
        if (stall !== 1'b1) begin
            failed++;
            $display("FAIL same_cycle_hold: stall=%b expected 1", stall);
        end
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        a_valid = 1; a_rd = 5'd0; a_data = 32'hDEAD_BEEF;
        #1;
        tests++;
        if (a_ready !== 1'b1) begin
            failed++;
            $display("FAIL zero_ready: a_ready=%b expected 1", a_ready);
        end
        tick();
        a_valid = 0;
        tests++;
        if (RegWrite !== 1'b0) begin
            failed++;
            $display("FAIL zero_regwrite: RegWrite=%b expected 0", RegWrite);
        end
        issue_valid = 1; issue_rd = 5'd0;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            failed++;
            $display("FAIL zero_issue_stall: stall=%b expected 0", stall);
        end
        tick();
        issue_valid = 0; src1_rd = 5'd0; src2_rd = 5'd0;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            failed++;
            $display("FAIL zero_src_stall: stall=%b expected 0", stall);
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        // Load-only grant moves the pointer to favour the ALU; also mark r2 pending.
        b_valid = 1; b_rd = 5'd12; b_data = 32'h0000_0012;
        issue_valid = 1; issue_rd = 5'd2;
        tick();
        b_valid = 0; issue_valid = 0;
        a_valid = 1; a_rd = 5'd6; a_data = 32'h0000_0066;
        tick();
        a_valid = 0;
        // Write of r6 is sitting in the write stage; reset now with traffic present.
        rst = 1;
        a_valid = 1; a_rd = 5'd3; b_valid = 1; b_rd = 5'd4; src1_rd = 5'd2;
        #1;
        tests++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0 || stall !== 1'b0) begin
            failed++;
            $display("FAIL midreset_comb: a_ready=%b b_ready=%b stall=%b expected 0 0 0",
                     a_ready, b_ready, stall);
        end
        tick();
        tests++;
        if (RegWrite !== 1'b0 || WriteRegister !== '0 || WriteData !== '0) begin
            failed++;
            $display("FAIL midreset_wport: RegWrite=%b WR=%0d WD=%h expected 0 0 0",
                     RegWrite, WriteRegister, WriteData);
        end
        rst = 0;
        a_data = 32'hAAAA_0003; b_data = 32'hBBBB_0004;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            failed++;
            $display("FAIL midreset_pending: stall=%b expected 0", stall);
        end
        tests++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
            failed++;
            $display("FAIL midreset_ptr: a_ready=%b b_ready=%b expected 0 1", a_ready, b_ready);
        end
        tick();
        tests++;
        if (RegWrite !== 1'b1 || WriteRegister !== 5'd4) begin
            failed++;
            $display("FAIL midreset_first_grant: RegWrite=%b WR=%0d expected 1 4",
                     RegWrite, WriteRegister);
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_hazard();
        test_same_cycle();
        test_zero_reg();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, sets the GPR data width.
REQ-002 Parameter REG_AW, default 5, sets the register-index width (2**REG_AW registers).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 a_valid / a_rd / a_data  input  1 / REG_AW / DATA_W  ALU writeback request.
REQ-006 a_ready  output  1  ALU request accepted this cycle.
REQ-007 b_valid / b_rd / b_data  input  1 / REG_AW / DATA_W  load-unit writeback request.
REQ-008 b_ready  output  1  load request accepted this cycle.
REQ-009 issue_valid / issue_rd  input  1 / REG_AW  decode issues an instruction that will write issue_rd.
REQ-010 src1_rd / src2_rd  input  REG_AW each  decode source registers for the hazard check.
REQ-011 stall  output  1  decode must hold; an issue presented while stall=1 is ignored.
REQ-012 RegWrite / WriteRegister / WriteData  output  1 / REG_AW / DATA_W  GPR write port.

Function
REQ-013 A request is accepted when its valid and its ready are both 1 in the same cycle; at most one request is accepted per cycle.
REQ-014 a_ready and b_ready are combinational and never depend on each other.
REQ-015 With only one requester valid, that requester is granted.
REQ-016 With both requesters valid, a round-robin pointer grants the requester not granted most recently.
- The pointer toggles only on acceptance.
- After reset the pointer favours B.
REQ-017 An accepted request is registered into the write stage; one cycle later RegWrite=1 with WriteRegister=rd and WriteData=data (latency 1).
REQ-018 The write stage never back-pressures, because the GPR accepts a write every cycle.
REQ-019 An accepted request with rd=0 is consumed but produces RegWrite=0.
REQ-020 The scoreboard holds one pending bit per register; bit 0 is constantly 0.
REQ-021 An issue with issue_valid=1, stall=0 and issue_rd!=0 sets pending[issue_rd].
REQ-022 A cycle with RegWrite=1 clears pending[WriteRegister].
REQ-023 If the set of REQ-021 and the clear of REQ-022 target the same register in the same cycle, the set wins.
REQ-024 stall = pending[src1_rd] | pending[src2_rd] | (issue_valid & pending[issue_rd]), so RAW and WAW hazards both stall.
- The stall equation is combinational.
- Register 0 never stalls.
REQ-025 A writeback for a register that is not pending is still performed (no error is flagged).

Reset
REQ-026 While rst=1 at a clock edge, the following are forced to 0: all pending bits, RegWrite, WriteRegister and WriteData; the round-robin pointer is set to favour B.
REQ-027 During a reset cycle, a_ready=0, b_ready=0 and stall=0.
REQ-028 A request in the write stage when reset is asserted is discarded and not written.

Structure
REQ-029 The shared CPU package holds DATA_W and REG_AW defaults and a requester-id enum (REQ_ALU, REQ_LOAD).
REQ-030 The scoreboard (pending vector, set/clear logic, hazard compare) is one sub-module named gpr_scoreboard; the arbiter and write stage stay in gpr_wb_arbiter.

Verification
REQ-031 Single request: a_valid=1, a_rd=5, a_data=0x1234 -> a_ready=1; next cycle RegWrite=1, WriteRegister=5, WriteData=0x1234.
REQ-032 Contention: both valid for 4 cycles after reset (rd 3/4) -> grants in order B,A,B,A; one RegWrite per cycle.
REQ-033 Hazard: issue rd=7, then src1_rd=7 -> stall=1 until the cycle after RegWrite to r7; then stall=0.
REQ-034 Same-cycle set/clear: RegWrite to r9 coincides with a new issue rd=9 -> pending[9] stays 1 and stall remains 1 for src=9.
REQ-035 Zero register: request rd=0 accepted -> RegWrite stays 0; issue rd=0 -> no pending bit and stall=0.
REQ-036 Mid-operation reset: rst=1 with pending r2 and a queued write -> RegWrite=0 next cycle; src1_rd=2 gives stall=0; next contention grants B first.
